phase_gate_deadtime: RTL and testbench
======================================

Name: phase_gate_deadtime

Overview:
- Downstream stage of the dribbler/motor commutation logic.
- Consumes the three 2-bit phase codes and drives the six MOSFET gate lines of the three-phase bridge.
- Synchronizes and glitch-filters the codes, which derive combinationally from asynchronous Hall inputs.
- Inserts a programmable dead time so the high and low switches of a leg are never on together or back-to-back.

Parameters:
DEAD_CYCLES, 50, clocks both gates of a leg stay off between turn-off of one switch and turn-on of any switch (1 us at 50 MHz); legal range 1..2^CNT_W-1
CNT_W, 8, width of the per-phase dead-time counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
enable  input  1  global drive enable; low forces all legs toward float
a  input  2  phase A code from commutation logic
b  input  2  phase B code
c  input  2  phase C code
ah  output  1  phase A high-side gate, active high
al  output  1  phase A low-side gate, active high
bh  output  1  phase B high-side gate
bl  output  1  phase B low-side gate
ch  output  1  phase C high-side gate
cl  output  1  phase C low-side gate
illegal_code  output  1  sticky: a code of 2'b10 was accepted on some phase
dead_active  output  1  high while any leg is in DEAD

Behaviour:
- Reset: one clock, synchronous active-low (rst_n sampled on clk rising edge).
- Code map per phase:
  - 2'b11 = HIGH target (high on, low off).
  - 2'b00 = LOW target.
  - 2'b01 = FLOAT target.
  - 2'b10 = illegal: treated as FLOAT and sets illegal_code.
- Input path, per 2-bit code:
  - Two-flop synchronizer s1 -> s2, then s3 <= s2.
  - The target register loads s2 only when s2 == s3, so a value must persist 2 consecutive synchronized cycles.
  - A code held from before edge N is in the target at edge N+3.
  - Gate output changes at edge N+4 when the FSM permits.
  - A one-cycle glitch never reaches the target.
- enable low: every effective target is FLOAT, applied at the FSM input with no filter delay. The synchronizer keeps running.
- Per-phase FSM states: FLOAT, HIGH, LOW, DEAD. All gate outputs are registered.
  - FLOAT: both gates 0. Target HIGH -> HIGH; target LOW -> LOW; else stay.
  - HIGH: h=1, l=0. Target != HIGH -> DEAD, counter loaded with DEAD_CYCLES-1.
  - LOW: h=0, l=1. Target != LOW -> DEAD, counter loaded.
  - DEAD: both gates 0, counter decrements each clock. At counter==0 go to the current target (FLOAT, HIGH or LOW).
- Dead-time guarantees:
  - Exactly DEAD_CYCLES clocks of both-off between any switch turning off and any switch turning on.
  - A target change during DEAD does not restart the counter; the latest target at expiry wins.
  - A return to the original target also waits out the full dead time.
- Reset values:
  - All FSMs in DEAD with counter = DEAD_CYCLES-1.
  - All gates 0, illegal_code 0, dead_active 1.
  - Synchronizer and target registers = 2'b01.
  - First possible turn-on is DEAD_CYCLES clocks after rst_n rises.
- Reset mid-conduction: gates go 0 on the reset edge; the dead time after release still applies.
- illegal_code: set when any target register loads 2'b10. Cleared only by reset.
- dead_active: registered OR of the three (state==DEAD) signals.
- Invariant, checked by assertion: never h&l==1 on any leg, in any cycle.
- Legs are independent; simultaneous transitions on all three phases are legal.

Test Plan:
- Reset, DEAD_CYCLES=4, a=11 held -> ah=0 for 4 clocks after rst_n rises, then ah=1, al=0.
- a steady 11, then a=00 -> ah falls at N+4; ah=al=0 for exactly 4 clocks; al=1 on the 5th clock.
- a=11 steady with a single-cycle pulse to 00 -> ah stays 1, no DEAD entry, dead_active stays 0.
- b=10 held -> bh=bl=0, illegal_code=1, and it stays 1 after b returns to 11; only rst_n low clears it.
- Legs in HIGH, then enable dropped -> all legs enter DEAD next clock and reach FLOAT after 4 clocks. enable re-raised -> turn-on without extra dead time.
- c HIGH->LOW, c changed back to 11 during DEAD -> cl never asserts; ch re-asserts exactly 4 clocks after it fell.

Source files
------------

// File: rtl/phase_gate_deadtime.sv
// phase_gate_deadtime: turns three 2-bit phase codes into six bridge gate
// drives. Each code is synchronized and must hold for two synchronized
// cycles before it becomes a leg target. A per-leg FSM inserts a fixed dead
// time between any switch turning off and any switch turning on.

module phase_gate_deadtime_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic ah,
    input  logic al,
    input  logic bh,
    input  logic bl,
    input  logic ch,
    input  logic cl
);

    // Shoot-through guard: a leg must never have both switches on.
    assert property (@(posedge clk) disable iff (!rst_n) !(ah && al));
    assert property (@(posedge clk) disable iff (!rst_n) !(bh && bl));
    assert property (@(posedge clk) disable iff (!rst_n) !(ch && cl));

endmodule

module phase_gate_deadtime #(
    parameter int DEAD_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    output logic       ah,
    output logic       al,
    output logic       bh,
    output logic       bl,
    output logic       ch,
    output logic       cl,
    output logic       illegal_code,
    output logic       dead_active
);

    typedef enum logic [1:0] {
        ST_FLOAT = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_DEAD  = 2'd3
    } leg_state_t;

    localparam logic [1:0]       CODE_HIGH  = 2'b11;
    localparam logic [1:0]       CODE_LOW   = 2'b00;
    localparam logic [1:0]       CODE_FLOAT = 2'b01;
    localparam logic [1:0]       CODE_BAD   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0] code_s [3];
    logic [2:0] gate_h_s;
    logic [2:0] gate_l_s;
    logic [2:0] dead_nx_s;
    logic [2:0] bad_load_s;
    logic       illegal_r;
    logic       dead_active_r;

    assign code_s[0] = a;
    assign code_s[1] = b;
    assign code_s[2] = c;

    for (genvar g = 0; g < 3; g++) begin : g_leg
        logic [1:0]       s1_r;
        logic [1:0]       s2_r;
        logic [1:0]       s3_r;
        logic [1:0]       tgt_r;
        logic [1:0]       eff_s;
        leg_state_t       state_r;
        leg_state_t       state_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_s;
        logic             h_r;
        logic             l_r;

        // Synchronize the code and accept it only once two synchronized samples agree.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_r  <= CODE_FLOAT;
                s2_r  <= CODE_FLOAT;
                s3_r  <= CODE_FLOAT;
                tgt_r <= CODE_FLOAT;
            end else begin
                s1_r <= code_s[g];
                s2_r <= s1_r;
                s3_r <= s2_r;
                if (s2_r == s3_r) begin
                    tgt_r <= s2_r;
                end else begin
                    tgt_r <= tgt_r;
                end
            end
        end

        assign bad_load_s[g] = (s2_r == s3_r) && (s2_r == CODE_BAD);

        // Effective target: disabled drive or an illegal code both mean float.
        always_comb begin
            eff_s = CODE_FLOAT;
            if (!enable) begin
                eff_s = CODE_FLOAT;
            end else begin
                case (tgt_r)
                    CODE_HIGH: eff_s = CODE_HIGH;
                    CODE_LOW:  eff_s = CODE_LOW;
                    default:   eff_s = CODE_FLOAT;
                endcase
            end
        end

        // Leg FSM next state: every exit from a conducting state goes through DEAD.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            case (state_r)
                ST_FLOAT: begin
                    if (eff_s == CODE_HIGH) begin
                        state_s = ST_HIGH;
                    end else if (eff_s == CODE_LOW) begin
                        state_s = ST_LOW;
                    end else begin
                        state_s = ST_FLOAT;
                    end
                end
                ST_HIGH: begin
                    if (eff_s != CODE_HIGH) begin
                        state_s = ST_DEAD;
                        cnt_s   = CNT_LOAD;
                    end else begin
                        state_s = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (eff_s != CODE_LOW) begin
                        state_s = ST_DEAD;
                        cnt_s   = CNT_LOAD;
                    end else begin
                        state_s = ST_LOW;
                    end
                end
                ST_DEAD: begin
                    if (cnt_r == CNT_ZERO) begin
                        case (eff_s)
                            CODE_HIGH: state_s = ST_HIGH;
                            CODE_LOW:  state_s = ST_LOW;
                            default:   state_s = ST_FLOAT;
                        endcase
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_DEAD;
                    cnt_s   = CNT_LOAD;
                end
            endcase
        end

        // Leg state, dead-time counter and registered gate drives.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_r <= ST_DEAD;
                cnt_r   <= CNT_LOAD;
                h_r     <= 1'b0;
                l_r     <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                h_r     <= (state_s == ST_HIGH);
                l_r     <= (state_s == ST_LOW);
            end
        end

        assign gate_h_s[g]  = h_r;
        assign gate_l_s[g]  = l_r;
        assign dead_nx_s[g] = (state_s == ST_DEAD);
    end

    // Sticky illegal-code flag and dead-time status, aligned with the gates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_r     <= 1'b0;
            dead_active_r <= 1'b1;
        end else begin
            illegal_r     <= illegal_r | (|bad_load_s);
            dead_active_r <= |dead_nx_s;
        end
    end

    assign ah           = gate_h_s[0];
    assign al           = gate_l_s[0];
    assign bh           = gate_h_s[1];
    assign bl           = gate_l_s[1];
    assign ch           = gate_h_s[2];
    assign cl           = gate_l_s[2];
    assign illegal_code = illegal_r;
    assign dead_active  = dead_active_r;

    phase_gate_deadtime_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .ah    (ah),
        .al    (al),
        .bh    (bh),
        .bl    (bl),
        .ch    (ch),
        .cl    (cl)
    );

endmodule

// File: tb/tb_phase_gate_deadtime.sv
// Directed bench for phase_gate_deadtime with a dead time of 4 clocks.
// Inputs change and outputs are sampled on the falling edge.

module tb_phase_gate_deadtime;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    logic       ah;
    logic       al;
    logic       bh;
    logic       bl;
    logic       ch;
    logic       cl;
    logic       illegal_code;
    logic       dead_active;

    int total = 0;
    int bad   = 0;

    phase_gate_deadtime #(
        .DEAD_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .a            (a),
        .b            (b),
        .c            (c),
        .ah           (ah),
        .al           (al),
        .bh           (bh),
        .bl           (bl),
        .ch           (ch),
        .cl           (cl),
        .illegal_code (illegal_code),
        .dead_active  (dead_active)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge to the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        a      = 2'b11;
        b      = 2'b01;
        c      = 2'b01;
        step(2);

        // Reset state.
        chk("rst_ah", ah, 1'b0);
        chk("rst_al", al, 1'b0);
        chk("rst_bh", bh, 1'b0);
        chk("rst_ch", ch, 1'b0);
        chk("rst_illegal", illegal_code, 1'b0);
        chk("rst_dead", dead_active, 1'b1);

        // Release: target is ready 4 edges later, ah turns on at the 5th edge.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("start_ah_off", ah, 1'b0);
        end
        step(1);
        chk("start_ah_on", ah, 1'b1);
        chk("start_al_off", al, 1'b0);
        chk("start_dead_clr", dead_active, 1'b0);

        // One-cycle glitch to 00 must be filtered out.
        a = 2'b00;
        step(1);
        a = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("glitch_ah", ah, 1'b1);
            chk("glitch_dead", dead_active, 1'b0);
        end

        // HIGH -> LOW: ah falls at N+4, 4 clocks both-off, al on at N+8.
        a = 2'b00;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("hl_ah_hold", ah, 1'b1);
        end
        step(1);
        chk("hl_ah_fall", ah, 1'b0);
        chk("hl_al_wait", al, 1'b0);
        chk("hl_dead_on", dead_active, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("hl_dead_ah", ah, 1'b0);
            chk("hl_dead_al", al, 1'b0);
        end
        step(1);
        chk("hl_al_on", al, 1'b1);
        chk("hl_ah_off", ah, 1'b0);
        chk("hl_dead_off", dead_active, 1'b0);

        // Bring all legs to HIGH.
        a = 2'b11;
        b = 2'b11;
        c = 2'b11;
        step(16);
        chk("allhi_ah", ah, 1'b1);
        chk("allhi_bh", bh, 1'b1);
        chk("allhi_ch", ch, 1'b1);

        // Drop enable: DEAD at the next edge, FLOAT 4 edges later.
        enable = 1'b0;
        step(1);
        chk("en_ah_off", ah, 1'b0);
        chk("en_bh_off", bh, 1'b0);
        chk("en_ch_off", ch, 1'b0);
        chk("en_dead_on", dead_active, 1'b1);
        step(3);
        chk("en_dead_hold", dead_active, 1'b1);
        step(1);
        chk("en_float", dead_active, 1'b0);
        chk("en_float_ah", ah, 1'b0);
        chk("en_float_al", al, 1'b0);

        // Re-raise enable: FLOAT -> HIGH on the next edge.
        enable = 1'b1;
        step(1);
        chk("reen_ah", ah, 1'b1);
        chk("reen_bh", bh, 1'b1);
        chk("reen_ch", ch, 1'b1);

        // c: 00 for two cycles then back to 11; target returns to HIGH during DEAD.
        c = 2'b00;
        step(1);
        chk("cret_ch0", ch, 1'b1);
        step(1);
        chk("cret_ch1", ch, 1'b1);
        c = 2'b11;
        step(2);
        chk("cret_ch3", ch, 1'b1);
        step(1);
        chk("cret_ch_fall", ch, 1'b0);
        chk("cret_cl_fall", cl, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("cret_dead_ch", ch, 1'b0);
            chk("cret_dead_cl", cl, 1'b0);
        end
        step(1);
        chk("cret_ch_back", ch, 1'b1);
        chk("cret_cl_never", cl, 1'b0);
        chk("cret_ah_indep", ah, 1'b1);

        // Illegal code on b: flag rises when the target loads 10, leg floats.
        b = 2'b10;
        step(3);
        chk("ill_pre", illegal_code, 1'b0);
        step(1);
        chk("ill_set", illegal_code, 1'b1);
        step(6);
        chk("ill_bh", bh, 1'b0);
        chk("ill_bl", bl, 1'b0);
        chk("ill_dead_clr", dead_active, 1'b0);
        b = 2'b11;
        step(12);
        chk("ill_bh_back", bh, 1'b1);
        chk("ill_sticky", illegal_code, 1'b1);

        // Reset mid-conduction: gates drop on the reset edge, dead time follows.
        rst_n = 1'b0;
        step(1);
        chk("mrst_ah", ah, 1'b0);
        chk("mrst_bh", bh, 1'b0);
        chk("mrst_ch", ch, 1'b0);
        chk("mrst_illegal", illegal_code, 1'b0);
        chk("mrst_dead", dead_active, 1'b1);
        rst_n = 1'b1;
        step(4);
        chk("mrst_ah_wait", ah, 1'b0);
        step(1);
        chk("mrst_ah_on", ah, 1'b1);
        chk("mrst_illegal_stay", illegal_code, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
